// File: rtl/mem_copy_engine.sv
// Block-copy bus initiator for a single-port word memory: one read cycle then one write cycle per word.
// Optional fill mode (macro MEM_COPY_FILL_EN) writes a latched constant to N words, one word per cycle.
module mem_copy_engine #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 10
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Start,
   input  logic [ADDR_WIDTH-1:0] SrcAddr,
   input  logic [ADDR_WIDTH-1:0] DstAddr,
   input  logic [LEN_WIDTH-1:0]  Length,
`ifdef MEM_COPY_FILL_EN
   input  logic                  FillEn,
   input  logic [DATA_WIDTH-1:0] FillValue,
`endif
   output logic                  Busy,
   output logic                  Done,
   output logic                  Error,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic [DATA_WIDTH-1:0] WriteData,
   output logic                  MemWrite,
   output logic                  MemRead,
   input  logic [DATA_WIDTH-1:0] ReadData
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(3'd4);
   localparam logic [LEN_WIDTH-1:0]  LEN_ZERO   = {LEN_WIDTH{1'b0}};
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = LEN_WIDTH'(1'b1);

   logic [1:0]            state_r,     state_s;
   logic [ADDR_WIDTH-1:0] src_ptr_r,   src_ptr_s;
   logic [ADDR_WIDTH-1:0] dst_ptr_r,   dst_ptr_s;
   logic [LEN_WIDTH-1:0]  count_r,     count_s;
   logic [DATA_WIDTH-1:0] data_r,      data_s;
   logic                  fill_mode_r, fill_mode_s;
   logic                  busy_r,      busy_s;
   logic                  done_r,      done_s;
   logic                  error_r,     error_s;
   logic [ADDR_WIDTH-1:0] address_r,   address_s;
   logic                  mem_write_r, mem_write_s;
   logic                  mem_read_r,  mem_read_s;

   logic                  fill_req_s;
   logic [DATA_WIDTH-1:0] fill_value_s;
   logic                  misaligned_s;
   logic [ADDR_WIDTH-1:0] src_next_s;
   logic [ADDR_WIDTH-1:0] dst_next_s;

`ifdef MEM_COPY_FILL_EN
   assign fill_req_s   = FillEn;
   assign fill_value_s = FillValue;
`else
   assign fill_req_s   = 1'b0;
   assign fill_value_s = {DATA_WIDTH{1'b0}};
`endif

   // A fill never reads, so only the destination has to be word-aligned in that mode.
   assign misaligned_s = (DstAddr[1:0] != 2'b00) ||
                         ((SrcAddr[1:0] != 2'b00) && !fill_req_s);

   assign src_next_s = src_ptr_r + WORD_BYTES;
   assign dst_next_s = dst_ptr_r + WORD_BYTES;

   // Next-state and next-output computation; outputs are registered from these values.
   always_comb begin
      state_s     = state_r;
      src_ptr_s   = src_ptr_r;
      dst_ptr_s   = dst_ptr_r;
      count_s     = count_r;
      data_s      = data_r;
      fill_mode_s = fill_mode_r;
      busy_s      = 1'b0;
      done_s      = 1'b0;
      error_s     = 1'b0;
      mem_read_s  = 1'b0;
      mem_write_s = 1'b0;
      address_s   = address_r;
      case (state_r)
         IDLE: begin
            if (Start) begin
               src_ptr_s   = SrcAddr;
               dst_ptr_s   = DstAddr;
               count_s     = Length;
               fill_mode_s = fill_req_s;
               if (misaligned_s) begin
                  state_s = DONE;
                  done_s  = 1'b1;
                  error_s = 1'b1;
               end else if (Length == LEN_ZERO) begin
                  state_s = DONE;
                  done_s  = 1'b1;
               end else if (fill_req_s) begin
                  state_s     = WRITE;
                  busy_s      = 1'b1;
                  mem_write_s = 1'b1;
                  address_s   = DstAddr;
                  data_s      = fill_value_s;
               end else begin
                  state_s    = READ;
                  busy_s     = 1'b1;
                  mem_read_s = 1'b1;
                  address_s  = SrcAddr;
               end
            end else begin
               state_s = IDLE;
            end
         end
         READ: begin
            state_s     = WRITE;
            data_s      = ReadData;
            busy_s      = 1'b1;
            mem_write_s = 1'b1;
            address_s   = dst_ptr_r;
         end
         WRITE: begin
            count_s   = count_r - LEN_ONE;
            src_ptr_s = src_next_s;
            dst_ptr_s = dst_next_s;
            if (count_r == LEN_ONE) begin
               state_s = DONE;
               done_s  = 1'b1;
            end else if (fill_mode_r) begin
               state_s     = WRITE;
               busy_s      = 1'b1;
               mem_write_s = 1'b1;
               address_s   = dst_next_s;
            end else begin
               state_s    = READ;
               busy_s     = 1'b1;
               mem_read_s = 1'b1;
               address_s  = src_next_s;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset; a reset mid-copy simply abandons the block.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_r     <= IDLE;
         src_ptr_r   <= {ADDR_WIDTH{1'b0}};
         dst_ptr_r   <= {ADDR_WIDTH{1'b0}};
         count_r     <= {LEN_WIDTH{1'b0}};
         data_r      <= {DATA_WIDTH{1'b0}};
         fill_mode_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         error_r     <= 1'b0;
         address_r   <= {ADDR_WIDTH{1'b0}};
         mem_write_r <= 1'b0;
         mem_read_r  <= 1'b0;
      end else begin
         state_r     <= state_s;
         src_ptr_r   <= src_ptr_s;
         dst_ptr_r   <= dst_ptr_s;
         count_r     <= count_s;
         data_r      <= data_s;
         fill_mode_r <= fill_mode_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
         error_r     <= error_s;
         address_r   <= address_s;
         mem_write_r <= mem_write_s;
         mem_read_r  <= mem_read_s;
      end
   end

   assign Busy      = busy_r;
   assign Done      = done_r;
   assign Error     = error_r;
   assign Address   = address_r;
   assign WriteData = data_r;
   assign MemWrite  = mem_write_r;
   assign MemRead   = mem_read_r;

endmodule
